// File: rtl/dlyecho_pkg.sv
// Shared types and helpers for the multi-tap delay/echo stage.
//   state_t      : sequencer states
//   sat_to_width : clamp a signed value into a w-bit two's-complement range
//   MAX_NTAPS    : upper bound on the number of echo taps
package dlyecho_pkg;

  localparam int MAX_NTAPS = 8;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    FETCH,
    TAP_ADDR,
    TAP_CAP,
    SAT,
    WRITE,
    PUSH
  } state_t;

  // Result keeps the 64-bit container; caller slices the low w bits.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ringbuf_sp_ram.sv
// Single-port ring-buffer RAM with a registered read (1-cycle latency).
//   i_en    : port enable
//   i_we    : 1 = write i_wdata to i_addr, 0 = read i_addr into o_rdata
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : read data, valid the cycle after a read
module ringbuf_sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // No reset so the array maps onto block RAM; contents are cleared by the
  // sequencer's sweep instead.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      o_rdata       <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/dlyecho_multitap.sv
// Multi-tap delay/echo stage between the ADC input FIFO and the DAC output FIFO.
// Each sample: pop, read NTAPS delayed samples from the ring buffer, accumulate
// (dout*gain)>>>GAIN_FRAC, saturate, store dry or wet into the ring, push.
//   clk, reset                   : clock, async active-high reset
//   din, is_input_fifo_empty     : FWFT input FIFO
//   request_to_read_input_fifo   : pop strobe
//   is_output_fifo_full          : output FIFO backpressure
//   request_to_write_output_fifo : push strobe
//   fb_mode, tap_delay, tap_gain : per-sample configuration (latched at pop)
//   signal_with_effect/effect_only/through : registered results
//   clear_busy                   : ring-buffer clear sweep in progress
module dlyecho_multitap
  import dlyecho_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int NTAPS     = 3,
  parameter int GAIN_W    = 5,
  parameter int GAIN_FRAC = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       din,
  input  logic                    is_input_fifo_empty,
  output logic                    request_to_read_input_fifo,
  input  logic                    is_output_fifo_full,
  output logic                    request_to_write_output_fifo,
  input  logic                    fb_mode,
  input  logic [NTAPS*ADDR_W-1:0] tap_delay,
  input  logic [NTAPS*GAIN_W-1:0] tap_gain,
  output logic [DATA_W-1:0]       signal_with_effect,
  output logic [DATA_W-1:0]       signal_effect_only,
  output logic [DATA_W-1:0]       signal_through,
  output logic                    clear_busy
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  localparam int KW     = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  state_t                          r_state;
  logic [ADDR_W-1:0]               r_wp;
  logic [ADDR_W-1:0]               r_clr_addr;
  logic                            r_clear_busy;
  logic [KW-1:0]                   r_k;
  logic signed [DATA_W-1:0]        r_sample;
  logic                            r_fb;
  logic [NTAPS-1:0][ADDR_W-1:0]    r_dly;
  logic [NTAPS-1:0][GAIN_W-1:0]    r_gain;
  logic signed [ACC_W-1:0]         r_acc;
  logic [DATA_W-1:0]               r_eff;
  logic [DATA_W-1:0]               r_wet;
  logic [DATA_W-1:0]               r_thru;

  logic                            w_ram_en;
  logic                            w_ram_we;
  logic [ADDR_W-1:0]               w_ram_addr;
  logic [DATA_W-1:0]               w_ram_wdata;
  logic [DATA_W-1:0]               w_rdata;
  logic [ADDR_W-1:0]               w_dly_k;
  logic [GAIN_W-1:0]               w_gain_k;
  logic                            w_tap_on;
  logic signed [PROD_W-1:0]        w_prod;
  logic signed [PROD_W-1:0]        w_term;
  logic signed [63:0]              w_eff64;
  logic signed [63:0]              w_wet64;

  assign w_dly_k  = r_dly[r_k];
  assign w_gain_k = r_gain[r_k];
  assign w_tap_on = |w_dly_k;   // zero delay disables the tap

  // Gain is unsigned: zero-extend before the signed multiply.
  assign w_prod = PROD_W'($signed(w_rdata)) * PROD_W'($signed({1'b0, w_gain_k}));
  assign w_term = w_prod >>> GAIN_FRAC;

  assign w_eff64 = sat_to_width(64'(r_acc), DATA_W);
  assign w_wet64 = sat_to_width(64'(r_acc) + 64'(r_sample), DATA_W);

  // Strobes decode the state register so an async reset drops them at once.
  assign request_to_read_input_fifo   = (r_state == FETCH);
  assign request_to_write_output_fifo = (r_state == PUSH) && !is_output_fifo_full;

  assign signal_with_effect = r_wet;
  assign signal_effect_only = r_eff;
  assign signal_through     = r_thru;
  assign clear_busy         = r_clear_busy;

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_wp;
    w_ram_wdata = '0;
    case (r_state)
      CLEAR: begin
        w_ram_en   = r_clear_busy;
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr_addr;
      end
      TAP_ADDR: begin
        w_ram_en   = w_tap_on;
        w_ram_addr = r_wp - w_dly_k;
      end
      WRITE: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_wdata = r_fb ? r_wet : r_sample;
      end
      default: ;
    endcase
  end

  ringbuf_sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_wp         <= '0;
      r_clr_addr   <= '0;
      r_clear_busy <= 1'b0;
      r_k          <= '0;
      r_sample     <= '0;
      r_fb         <= 1'b0;
      r_dly        <= '0;
      r_gain       <= '0;
      r_acc        <= '0;
      r_eff        <= '0;
      r_wet        <= '0;
      r_thru       <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          // First cycle after reset only raises busy; the next 2^ADDR_W
          // cycles each zero one word.
          if (!r_clear_busy) begin
            r_clear_busy <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (&r_clr_addr) begin
              r_clear_busy <= 1'b0;
              r_state      <= IDLE;
            end
          end
        end
        IDLE: if (!is_input_fifo_empty) r_state <= FETCH;
        FETCH: begin
          r_sample <= $signed(din);
          r_fb     <= fb_mode;
          r_dly    <= tap_delay;
          r_gain   <= tap_gain;
          r_acc    <= '0;
          r_k      <= '0;
          r_state  <= TAP_ADDR;
        end
        TAP_ADDR: r_state <= TAP_CAP;
        TAP_CAP: begin
          if (w_tap_on) r_acc <= r_acc + ACC_W'(w_term);
          if (r_k == KW'(NTAPS - 1)) begin
            r_state <= SAT;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= TAP_ADDR;
          end
        end
        SAT: begin
          r_eff   <= w_eff64[DATA_W-1:0];
          r_wet   <= w_wet64[DATA_W-1:0];
          r_thru  <= r_sample;
          r_state <= WRITE;
        end
        WRITE: r_state <= PUSH;
        PUSH: begin
          if (!is_output_fifo_full) begin
            r_wp    <= r_wp + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dlyecho_multitap.sv
module tb_dlyecho_multitap;
  localparam int DW = 16, AW = 4, NT = 3, GW = 5, GF = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW-1:0]     din = '0;
  logic              is_input_fifo_empty = 1'b0;
  logic              request_to_read_input_fifo;
  logic              is_output_fifo_full = 1'b0;
  logic              request_to_write_output_fifo;
  logic              fb_mode = 1'b0;
  logic [NT*AW-1:0]  tap_delay = '0;
  logic [NT*GW-1:0]  tap_gain = '0;
  logic [DW-1:0]     signal_with_effect;
  logic [DW-1:0]     signal_effect_only;
  logic [DW-1:0]     signal_through;
  logic              clear_busy;

  dlyecho_multitap #(.DATA_W(DW), .ADDR_W(AW), .NTAPS(NT), .GAIN_W(GW), .GAIN_FRAC(GF)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .din                          (din),
    .is_input_fifo_empty          (is_input_fifo_empty),
    .request_to_read_input_fifo   (request_to_read_input_fifo),
    .is_output_fifo_full          (is_output_fifo_full),
    .request_to_write_output_fifo (request_to_write_output_fifo),
    .fb_mode                      (fb_mode),
    .tap_delay                    (tap_delay),
    .tap_gain                     (tap_gain),
    .signal_with_effect           (signal_with_effect),
    .signal_effect_only           (signal_effect_only),
    .signal_through               (signal_through),
    .clear_busy                   (clear_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit rst;
    int din;
    bit fb;
    int d0, d1, d2;
    int g0, g1, g2;
    int eff;
    int wet;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint eff_s();
    return longint'($signed(signal_effect_only));
  endfunction
  function automatic longint wet_s();
    return longint'($signed(signal_with_effect));
  endfunction
  function automatic longint thru_s();
    return longint'($signed(signal_through));
  endfunction

  task automatic set_cfg(input int dv, input bit fb, input int d0, input int d1, input int d2,
                         input int g0, input int g1, input int g2);
    din       = dv[DW-1:0];
    fb_mode   = fb;
    tap_delay = {AW'(d2), AW'(d1), AW'(d0)};
    tap_gain  = {GW'(g2), GW'(g1), GW'(g0)};
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset = 1'b1;
    is_input_fifo_empty = 1'b1;
    is_output_fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!clear_busy && n < 5) begin @(negedge clk); n++; end
    while (clear_busy && n < 40) begin @(negedge clk); n++; end
    chk("clear_done", (clear_busy == 1'b0 && n < 40) ? 1 : 0, 1);
  endtask

  // Present one sample, wait for its pop, scramble config after the pop edge,
  // and return the pop-to-push distance (-1 on timeout).
  task automatic run_sample(input int dv, input bit fb, input int d0, input int d1, input int d2,
                            input int g0, input int g1, input int g2, output int lat);
    int n;
    set_cfg(dv, fb, d0, d1, d2, g0, g1, g2);
    is_input_fifo_empty = 1'b0;
    n = 0;
    while (!request_to_read_input_fifo && n < 200) begin @(negedge clk); n++; end
    is_input_fifo_empty = 1'b1;
    if (!request_to_read_input_fifo) begin
      lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    tap_gain  = (NT*GW)'($urandom);
    tap_delay = (NT*AW)'($urandom);
    fb_mode   = ~fb;
    din       = DW'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!request_to_write_output_fifo && n < 100);
    lat = request_to_write_output_fifo ? n : -1;
  endtask

  initial begin
    int lat, busy, first_rd, push_c, nz, pops, pushes, unstable, n, bad;

    // rst, din, fb, d0,d1,d2, g0,g1,g2, eff, wet
    // Impulse, feedforward
    tv.push_back('{1, 1000, 0, 2, 4, 6, 13, 11, 9,   0, 1000});
    tv.push_back('{0,    0, 0, 2, 4, 6, 13, 11, 9,   0,    0});
    tv.push_back('{0,    0, 0, 2, 4, 6, 13, 11, 9, 812,  812});
    tv.push_back('{0,    0, 0, 2, 4, 6, 13, 11, 9,   0,    0});
    tv.push_back('{0,    0, 0, 2, 4, 6, 13, 11, 9, 687,  687});
    tv.push_back('{0,    0, 0, 2, 4, 6, 13, 11, 9,   0,    0});
    tv.push_back('{0,    0, 0, 2, 4, 6, 13, 11, 9, 562,  562});
    // Saturation of the wet sum
    tv.push_back('{1,  30000, 0, 1, 0, 0, 16, 0, 0,      0,  30000});
    tv.push_back('{0,  30000, 0, 1, 0, 0, 16, 0, 0,  30000,  32767});
    tv.push_back('{1, -30000, 0, 1, 0, 0, 16, 0, 0,      0, -30000});
    tv.push_back('{0, -30000, 0, 1, 0, 0, 16, 0, 0, -30000, -32768});
    // Negative product rounds toward minus infinity
    tv.push_back('{1,  -1000, 0, 1, 0, 0, 13, 0, 0,      0,  -1000});
    tv.push_back('{0,      0, 0, 1, 0, 0, 13, 0, 0,   -813,   -813});
    // Effect-only saturation: single tap and three stacked taps
    tv.push_back('{1, -32768, 0, 1, 0, 0, 31, 0, 0,      0, -32768});
    tv.push_back('{0,      0, 0, 1, 0, 0, 31, 0, 0, -32768, -32768});
    tv.push_back('{1,  32767, 0, 1, 1, 1, 31, 31, 31,    0,  32767});
    tv.push_back('{0,     -5, 0, 1, 1, 1, 31, 31, 31, 32767, 32767});
    // Feedback
    tv.push_back('{1, 1024, 1, 2, 0, 0, 8, 0, 0,   0, 1024});
    tv.push_back('{0,    0, 1, 2, 0, 0, 8, 0, 0,   0,    0});
    tv.push_back('{0,    0, 1, 2, 0, 0, 8, 0, 0, 512,  512});
    tv.push_back('{0,    0, 1, 2, 0, 0, 8, 0, 0,   0,    0});
    tv.push_back('{0,    0, 1, 2, 0, 0, 8, 0, 0, 256,  256});
    tv.push_back('{0,    0, 1, 2, 0, 0, 8, 0, 0,   0,    0});
    tv.push_back('{0,    0, 1, 2, 0, 0, 8, 0, 0, 128,  128});

    // ---- reset state and clear sweep ----
    set_cfg(123, 0, 0, 0, 0, 0, 0, 0);
    is_input_fifo_empty = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd",    request_to_read_input_fifo, 0);
    chk("rst_wr",    request_to_write_output_fifo, 0);
    chk("rst_busy",  clear_busy, 0);
    chk("rst_outs",  (signal_with_effect | signal_effect_only | signal_through) == 0 ? 1 : 0, 1);
    reset = 1'b0;
    busy = 0; first_rd = 0; push_c = 0; nz = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (clear_busy) busy++;
      if (request_to_read_input_fifo && first_rd == 0) begin
        first_rd = c;
        is_input_fifo_empty = 1'b1;
      end
      if (request_to_write_output_fifo && push_c == 0) push_c = c;
      if (c < 18 && (signal_with_effect | signal_effect_only | signal_through) != 0) nz++;
    end
    chk("clear_busy_cycles", busy, 16);
    chk("first_pop_cycle", first_rd, 18);
    chk("outs_zero_pre_pop", nz, 0);
    chk("first_push_cycle", push_c, 27);
    chk("first_thru", thru_s(), 123);

    // Empty input at IDLE: no strobes
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (request_to_read_input_fifo || request_to_write_output_fifo) bad++;
    end
    chk("idle_no_strobe", bad, 0);

    // ---- table-driven vectors ----
    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      run_sample(tv[i].din, tv[i].fb, tv[i].d0, tv[i].d1, tv[i].d2,
                 tv[i].g0, tv[i].g1, tv[i].g2, lat);
      chk($sformatf("v%0d_latency", i), lat, 9);
      chk($sformatf("v%0d_effect", i), eff_s(), tv[i].eff);
      chk($sformatf("v%0d_wet", i), wet_s(), tv[i].wet);
      chk($sformatf("v%0d_thru", i), thru_s(), tv[i].din);
    end

    // ---- backpressure ----
    do_reset();
    is_output_fifo_full = 1'b1;
    set_cfg(2000, 0, 0, 0, 0, 0, 0, 0);
    is_input_fifo_empty = 1'b0;
    n = 0;
    while (!request_to_read_input_fifo && n < 50) begin @(negedge clk); n++; end
    chk("bp_pop_seen", request_to_read_input_fifo, 1);
    @(posedge clk);
    #1;
    set_cfg(0, 0, 1, 0, 0, 16, 0, 0);   // next sample waits in the FIFO
    pops = 0; pushes = 0; unstable = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (request_to_read_input_fifo) pops++;
      if (request_to_write_output_fifo) pushes++;
      if (i >= 9 && (wet_s() != 2000 || thru_s() != 2000)) unstable++;
    end
    @(posedge clk);
    #1;
    is_output_fifo_full = 1'b0;
    @(negedge clk);
    chk("bp_no_pop_hold", pops, 0);
    chk("bp_no_push_full", pushes, 0);
    chk("bp_outs_stable", unstable, 0);
    chk("bp_push_release", request_to_write_output_fifo, 1);
    @(negedge clk);
    chk("bp_push_single", request_to_write_output_fifo, 0);
    @(negedge clk);
    chk("bp_next_pop", request_to_read_input_fifo, 1);
    is_input_fifo_empty = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!request_to_write_output_fifo && n < 100);
    chk("bp_next_latency", n, 9);
    chk("bp_wp_once", eff_s(), 2000);

    // ---- async reset in TAP_CAP ----
    do_reset();
    run_sample(5000, 0, 0, 0, 0, 0, 0, 0, lat);
    run_sample(6000, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("pre_rst_thru", thru_s(), 6000);
    set_cfg(7000, 0, 1, 0, 0, 16, 0, 0);
    is_input_fifo_empty = 1'b0;
    n = 0;
    while (!request_to_read_input_fifo && n < 50) begin @(negedge clk); n++; end
    is_input_fifo_empty = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_rd", request_to_read_input_fifo, 0);
    chk("mid_rst_wr", request_to_write_output_fifo, 0);
    chk("mid_rst_outs", (signal_with_effect | signal_effect_only | signal_through) == 0 ? 1 : 0, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", clear_busy, 1);
    n = 0;
    while (clear_busy && n < 40) begin @(negedge clk); n++; end
    chk("mid_rst_clear_done", clear_busy, 0);
    // Delay 15 from wp=0 lands on address 1, which held 6000 before the sweep.
    run_sample(0, 0, 15, 0, 0, 16, 0, 0, lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_effect", eff_s(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
